// File: rtl/uart_tx_frame_pkg.sv
// Shared UART definitions: FSM state encoding, parity mode codes, default sizes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: tx_state_t, PAR_* codes, UART_DATA_MAX / UART_BREAK_LEN defaults, has_parity().
package uart_tx_frame_pkg;

   localparam int UART_DATA_MAX  = 9;
   localparam int UART_BREAK_LEN = 13;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP1  = 3'd4,
      ST_STOP2  = 3'd5,
      ST_BREAK  = 3'd6
   } tx_state_t;

   // Parity mode codes; 5..7 behave as PAR_NONE.
   localparam logic [2:0] PAR_NONE  = 3'd0;
   localparam logic [2:0] PAR_EVEN  = 3'd1;
   localparam logic [2:0] PAR_ODD   = 3'd2;
   localparam logic [2:0] PAR_MARK  = 3'd3;
   localparam logic [2:0] PAR_SPACE = 3'd4;

   function automatic logic has_parity(input logic [2:0] mode);
      return (mode >= PAR_EVEN) && (mode <= PAR_SPACE);
   endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Frame request bus between a TX byte source and the UART frame serialiser.
// Latency: n/a (wires only).
// Backpressure: source holds in_valid and payload/config until in_ready is seen at a clock edge.
// Signals: in_valid/in_ready handshake, in_data payload, cfg_* per-frame format, send_break.
interface uart_tx_frame_if #(
   parameter int DATA_MAX = 9
);
   logic                in_valid;
   logic                in_ready;
   logic [DATA_MAX-1:0] in_data;
   logic [4:0]          cfg_len;
   logic [2:0]          cfg_parity;
   logic                cfg_stop2;
   logic                cfg_msb_first;
   logic                send_break;

   modport master (
      output in_valid, in_data, cfg_len, cfg_parity, cfg_stop2, cfg_msb_first, send_break,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_data, cfg_len, cfg_parity, cfg_stop2, cfg_msb_first, send_break,
      output in_ready
   );
endinterface

// File: rtl/uart_parity_gen.sv
// UART parity over the low len bits of data, for both transmitter and receiver checker.
// Latency: combinational.
// Backpressure: none.
// Ports: data[W], len (number of used bits), mode (PAR_* code) -> par.
module uart_parity_gen
   import uart_tx_frame_pkg::*;
#(
   parameter int W = UART_DATA_MAX
) (
   input  logic [W-1:0] data,
   input  logic [4:0]   len,
   input  logic [2:0]   mode,
   output logic         par
);

   logic x;

   always_comb begin
      x = 1'b0;
      // Bits at or above len are payload padding and must not affect parity.
      for (int k = 0; k < W; k++) begin
         if (k < int'(len)) begin
            x = x ^ data[k];
         end
      end

      par = 1'b0;
      case (mode)
         PAR_EVEN: par = x;
         PAR_ODD:  par = ~x;
         PAR_MARK: par = 1'b1;
         default:  par = 1'b0;
      endcase
   end

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame serialiser: start, 5..DATA_MAX data bits, optional parity, 1/2 stop bits, breaks.
// Latency: tx shows the start bit in the cycle after the accepting edge; one bit per baud_clk.
// Backpressure: in_ready only in IDLE or the final stop bit; send_break pre-empts in_valid there.
// Ports: baud_clk, arst_n, bus (slave: request handshake + cfg), tx, busy, parity_bit, frame_done.
module uart_tx_frame
   import uart_tx_frame_pkg::*;
#(
   parameter int DATA_MAX  = UART_DATA_MAX,
   parameter int BREAK_LEN = UART_BREAK_LEN
) (
   input  logic             baud_clk,
   input  logic             arst_n,
   uart_tx_frame_if.slave   bus,
   output logic             tx,
   output logic             busy,
   output logic             parity_bit,
   output logic             frame_done
);

   localparam int CW = $clog2(DATA_MAX + 1);
   localparam int BW = $clog2(BREAK_LEN + 1);

   tx_state_t           state_q, state_d;
   logic                tx_q, tx_d;
   logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
   logic [BW-1:0]       brk_cnt_q, brk_cnt_d;
   logic [DATA_MAX-1:0] shift_q, shift_d;
   logic [4:0]          len_q, len_d;
   logic                has_par_q, has_par_d;
   logic                stop2_q, stop2_d;
   logic                par_q, par_d;

   logic [4:0]          len_c;
   logic [DATA_MAX-1:0] ordered;
   logic                par_c;
   logic                last_stop;
   logic                rdy;
   logic                last_bit;
   logic                last_brk;

   // Clamp the requested length so no index can fall outside in_data.
   always_comb begin
      if (bus.cfg_len < 5'd5) begin
         len_c = 5'd5;
      end else if (bus.cfg_len > 5'(DATA_MAX)) begin
         len_c = 5'(DATA_MAX);
      end else begin
         len_c = bus.cfg_len;
      end
   end

   // Pre-order the payload at accept so DATA always shifts out bit 0;
   // MSB-first is a bit reversal of the used field, unused bits are zeroed.
   always_comb begin
      ordered = '0;
      for (int k = 0; k < DATA_MAX; k++) begin
         for (int j = 0; j < DATA_MAX; j++) begin
            if ((k < int'(len_c)) &&
                (j == (bus.cfg_msb_first ? (int'(len_c) - 1 - k) : k))) begin
               ordered[k] = bus.in_data[j];
            end
         end
      end
   end

   uart_parity_gen #(
      .W (DATA_MAX)
   ) u_parity (
      .data (bus.in_data),
      .len  (len_c),
      .mode (bus.cfg_parity),
      .par  (par_c)
   );

   assign last_stop = (state_q == ST_STOP2) || ((state_q == ST_STOP1) && !stop2_q);
   assign rdy       = (state_q == ST_IDLE) || last_stop;
   assign last_bit  = (5'(bit_cnt_q) == (len_q - 5'd1));
   assign last_brk  = (brk_cnt_q == BW'(BREAK_LEN - 1));

   always_comb begin
      state_d   = state_q;
      tx_d      = tx_q;
      bit_cnt_d = bit_cnt_q;
      brk_cnt_d = brk_cnt_q;
      shift_d   = shift_q;
      len_d     = len_q;
      has_par_d = has_par_q;
      stop2_d   = stop2_q;
      par_d     = par_q;

      if (rdy) begin
         // Idle or final stop bit: start a break, chain the next frame, or go idle.
         if (bus.send_break) begin
            state_d   = ST_BREAK;
            tx_d      = 1'b0;
            brk_cnt_d = '0;
            stop2_d   = 1'b0;   // a break always ends with a single stop bit
         end else if (bus.in_valid) begin
            state_d   = ST_START;
            tx_d      = 1'b0;
            shift_d   = ordered;
            len_d     = len_c;
            has_par_d = has_parity(bus.cfg_parity);
            stop2_d   = bus.cfg_stop2;
            par_d     = par_c;
         end else begin
            state_d   = ST_IDLE;
            tx_d      = 1'b1;
         end
      end else begin
         case (state_q)
            ST_START: begin
               state_d   = ST_DATA;
               tx_d      = shift_q[0];
               shift_d   = shift_q >> 1;
               bit_cnt_d = '0;
            end
            ST_DATA: begin
               if (last_bit) begin
                  state_d = has_par_q ? ST_PARITY : ST_STOP1;
                  tx_d    = has_par_q ? par_q : 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + CW'(1);
                  tx_d      = shift_q[0];
                  shift_d   = shift_q >> 1;
               end
            end
            ST_PARITY: begin
               state_d = ST_STOP1;
               tx_d    = 1'b1;
            end
            ST_STOP1: begin
               // Only reached with stop2 set; the single-stop case is handled by rdy.
               state_d = ST_STOP2;
               tx_d    = 1'b1;
            end
            ST_BREAK: begin
               if (last_brk) begin
                  state_d = ST_STOP1;
                  tx_d    = 1'b1;
               end else begin
                  brk_cnt_d = brk_cnt_q + BW'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               tx_d    = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge baud_clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q   <= ST_IDLE;
         tx_q      <= 1'b1;
         bit_cnt_q <= '0;
         brk_cnt_q <= '0;
         shift_q   <= '0;
         len_q     <= '0;
         has_par_q <= 1'b0;
         stop2_q   <= 1'b0;
         par_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         tx_q      <= tx_d;
         bit_cnt_q <= bit_cnt_d;
         brk_cnt_q <= brk_cnt_d;
         shift_q   <= shift_d;
         len_q     <= len_d;
         has_par_q <= has_par_d;
         stop2_q   <= stop2_d;
         par_q     <= par_d;
      end
   end

   assign tx           = tx_q;
   assign busy         = (state_q != ST_IDLE);
   assign parity_bit   = par_q;
   assign frame_done   = last_stop;
   assign bus.in_ready = rdy;

endmodule

// File: tb/tb_uart_tx_frame.sv
module tb_uart_tx_frame;

   logic baud_clk;
   logic arst_n;
   logic tx, busy, parity_bit, frame_done;

   uart_tx_frame_if #(.DATA_MAX(9)) bus ();

   uart_tx_frame #(
      .DATA_MAX  (9),
      .BREAK_LEN (13)
   ) dut (
      .baud_clk   (baud_clk),
      .arst_n     (arst_n),
      .bus        (bus),
      .tx         (tx),
      .busy       (busy),
      .parity_bit (parity_bit),
      .frame_done (frame_done)
   );

   initial begin
      baud_clk = 1'b0;
      forever #5 baud_clk = ~baud_clk;
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [8:0]  data;
      logic [4:0]  len;
      logic [2:0]  par;
      logic        stop2;
      logic        msb;
      int          nbits;
      logic [19:0] exp_tx;   // bit i = tx in frame cycle i (cycle 0 = start bit)
      logic        exp_par;
   } vec_t;

   vec_t vecs[6];

   // ---------------- behavioural reference model ----------------
   typedef struct {
      logic tx;
      logic fd;
   } cyc_t;

   cyc_t  mq[$];
   logic  mexp_par = 1'b0;
   int    n_acc = 0;
   string phase = "init";

   task automatic put(input logic t, input logic f);
      cyc_t c;
      c.tx = t;
      c.fd = f;
      mq.push_back(c);
   endtask

   task automatic push_frame(input logic [8:0] d, input logic [4:0] l, input logic [2:0] p,
                             input logic s2, input logic m);
      int n;
      int ones;
      logic pb;
      logic [8:0] t;
      n = (l < 5) ? 5 : ((l > 9) ? 9 : int'(l));
      put(1'b0, 1'b0);
      ones = 0;
      for (int i = 0; i < n; i++) begin
         t = d >> (m ? (n - 1 - i) : i);
         put(t[0], 1'b0);
         t = d >> i;
         ones += int'(t[0]);
      end
      case (p)
         3'd1:    pb = (ones % 2) == 1;
         3'd2:    pb = (ones % 2) == 0;
         3'd3:    pb = 1'b1;
         default: pb = 1'b0;
      endcase
      if (p >= 3'd1 && p <= 3'd4) put(pb, 1'b0);
      put(1'b1, !s2);
      if (s2) put(1'b1, 1'b1);
      mexp_par = pb;
   endtask

   task automatic push_break();
      for (int i = 0; i < 13; i++) put(1'b0, 1'b0);
      put(1'b1, 1'b1);
   endtask

   // One cycle: compare DUT against the model's current cycle, then drive the next request.
   task automatic step(input logic v, input logic b, input logic [8:0] d, input logic [4:0] l,
                       input logic [2:0] p, input logic s2, input logic m);
      logic rdy_m;
      @(negedge baud_clk);
      if (mq.size() == 0) begin
         chk({phase, " idle tx"}, 32'(tx), 32'd1);
         chk({phase, " idle busy"}, 32'(busy), 32'd0);
         chk({phase, " idle frame_done"}, 32'(frame_done), 32'd0);
         chk({phase, " idle in_ready"}, 32'(bus.in_ready), 32'd1);
         rdy_m = 1'b1;
      end else begin
         chk({phase, " tx"}, 32'(tx), 32'(mq[0].tx));
         chk({phase, " busy"}, 32'(busy), 32'd1);
         chk({phase, " frame_done"}, 32'(frame_done), 32'(mq[0].fd));
         chk({phase, " in_ready"}, 32'(bus.in_ready), 32'(mq[0].fd));
         rdy_m = mq[0].fd;
         void'(mq.pop_front());
      end
      chk({phase, " parity_bit"}, 32'(parity_bit), 32'(mexp_par));
      if (rdy_m && b) begin
         push_break();
      end else if (rdy_m && v) begin
         push_frame(d, l, p, s2, m);
         n_acc++;
      end
      bus.in_valid      = v;
      bus.send_break    = b;
      bus.in_data       = d;
      bus.cfg_len       = l;
      bus.cfg_parity    = p;
      bus.cfg_stop2     = s2;
      bus.cfg_msb_first = m;
   endtask

   task automatic drain(input int budget);
      int c;
      c = 0;
      while (mq.size() != 0 && c < budget) begin
         step(1'b0, 1'b0, 9'($urandom), 5'($urandom), 3'($urandom), 1'b0, 1'b0);
         c++;
      end
      chk({phase, " drained"}, 32'(mq.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [8:0] d;
      int cnt;

      vecs[0] = '{9'h075, 5'd8,  3'd1, 1'b0, 1'b0, 11, 20'b11011101010,   1'b1};
      vecs[1] = '{9'h02B, 5'd7,  3'd2, 1'b1, 1'b1, 11, 20'b11111010100,   1'b1};
      vecs[2] = '{9'h1F6, 5'd3,  3'd3, 1'b0, 1'b0, 8,  20'b11101100,      1'b1};
      vecs[3] = '{9'h1A5, 5'd20, 3'd4, 1'b1, 1'b0, 13, 20'b1101101001010, 1'b0};
      vecs[4] = '{9'h013, 5'd5,  3'd2, 1'b0, 1'b1, 8,  20'b10110010,      1'b0};
      vecs[5] = '{9'h02A, 5'd6,  3'd5, 1'b1, 1'b0, 9,  20'b111010100,     1'b0};

      arst_n            = 1'b0;
      bus.in_valid      = 1'b0;
      bus.send_break    = 1'b0;
      bus.in_data       = '0;
      bus.cfg_len       = 5'd8;
      bus.cfg_parity    = 3'd0;
      bus.cfg_stop2     = 1'b0;
      bus.cfg_msb_first = 1'b0;

      // reset state
      #12;
      chk("reset tx", 32'(tx), 32'd1);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset frame_done", 32'(frame_done), 32'd0);
      chk("reset parity_bit", 32'(parity_bit), 32'd0);
      chk("reset in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge baud_clk);
      arst_n = 1'b1;

      // directed vectors, each a single frame from idle
      for (int n = 0; n < 6; n++) begin
         bus.in_valid      = 1'b1;
         bus.in_data       = vecs[n].data;
         bus.cfg_len       = vecs[n].len;
         bus.cfg_parity    = vecs[n].par;
         bus.cfg_stop2     = vecs[n].stop2;
         bus.cfg_msb_first = vecs[n].msb;
         @(negedge baud_clk);
         bus.in_valid = 1'b0;
         for (int i = 0; i < vecs[n].nbits; i++) begin
            chk($sformatf("vec%0d tx[%0d]", n, i), 32'(tx), 32'(vecs[n].exp_tx[i]));
            chk($sformatf("vec%0d frame_done[%0d]", n, i), 32'(frame_done),
                32'(i == vecs[n].nbits - 1));
            chk($sformatf("vec%0d in_ready[%0d]", n, i), 32'(bus.in_ready),
                32'(i == vecs[n].nbits - 1));
            chk($sformatf("vec%0d busy[%0d]", n, i), 32'(busy), 32'd1);
            @(negedge baud_clk);
         end
         chk($sformatf("vec%0d end tx", n), 32'(tx), 32'd1);
         chk($sformatf("vec%0d end busy", n), 32'(busy), 32'd0);
         chk($sformatf("vec%0d parity_bit", n), 32'(parity_bit), 32'(vecs[n].exp_par));
      end
      mexp_par = vecs[5].exp_par;

      // three back-to-back frames with in_valid held high
      phase = "contig";
      n_acc = 0;
      cnt = 0;
      while (!(n_acc == 3 && mq.size() == 0) && cnt < 40) begin
         step(n_acc < 3, 1'b0, 9'($urandom), 5'd5, 3'd0, 1'b0, 1'b0);
         cnt++;
      end
      chk("contig frames accepted", 32'(n_acc), 32'd3);
      chk("contig cycles", 32'(cnt), 32'd22);

      // break and frame requested together in idle: break first, then the frame
      phase = "break";
      n_acc = 0;
      d = 9'h0C3;
      step(1'b1, 1'b1, d, 5'd8, 3'd1, 1'b0, 1'b0);
      cnt = 0;
      while (n_acc == 0 && cnt < 30) begin
         step(1'b1, 1'b0, d, 5'd8, 3'd1, 1'b0, 1'b0);
         cnt++;
      end
      chk("break cycles before frame", 32'(cnt), 32'd14);
      drain(30);

      // asynchronous reset during data bit 4
      phase = "rst";
      step(1'b1, 1'b0, 9'h0AF, 5'd8, 3'd2, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 9'h0AF, 5'd8, 3'd2, 1'b0, 1'b0);
      #2;
      arst_n = 1'b0;
      #1;
      chk("rst mid tx", 32'(tx), 32'd1);
      chk("rst mid busy", 32'(busy), 32'd0);
      chk("rst mid frame_done", 32'(frame_done), 32'd0);
      chk("rst mid in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst mid parity_bit", 32'(parity_bit), 32'd0);
      mq.delete();
      mexp_par = 1'b0;
      @(negedge baud_clk);
      arst_n = 1'b1;
      phase = "post_rst";
      step(1'b1, 1'b0, 9'h156, 5'd9, 3'd1, 1'b1, 1'b1);
      drain(30);

      // randomized traffic against the reference model
      phase = "rand";
      for (int i = 0; i < 800; i++) begin
         step($urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0, 9'($urandom),
              5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 1'($urandom),
              1'($urandom));
      end
      drain(40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
